div_sched: RTL
==============

# div_sched

Scheduler that shares one multi-cycle unsigned divider core among NREQ issue requesters in the RISC pipeline. Arbitrates round-robin, converts RISC-V DIV/DIVU/REM/REMU into an unsigned core operation with sign pre- and post-correction, and short-circuits divide-by-zero and signed overflow without starting the core. Returns one tagged result at a time to writeback and supports pipeline flush of the in-flight operation.

## Interface
- NREQ, 2: number of requesters (2..4)
- XLEN, 32: operand width
- TAG_W, 6: destination tag width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill the in-flight or pending operation
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot grant; accept when valid&ready
- req_a, req_b  in  NREQ*XLEN each  dividend, divisor; slot i at [i*XLEN +: XLEN]
- req_op  in  NREQ*2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- req_tag  in  NREQ*TAG_W  destination tag
- core_start  out  1  one-cycle start pulse to divider core
- core_a, core_b  out  XLEN  unsigned operands, held stable until core_done
- core_done  in  1  one-cycle completion pulse
- core_quo, core_rem  in  XLEN  unsigned results, valid with core_done
- rsp_valid  out  1  result available
- rsp_ready  in  1  writeback accepts
- rsp_data  out  XLEN  result
- rsp_tag  out  TAG_W  echoed tag
- rsp_src  out  $clog2(NREQ)  index of originating requester

## Operation
- States: IDLE, START, BUSY, DRAIN, RESP.
- IDLE: round-robin grant among req_valid, starting from pointer; req_ready is the grant, forced 0 when flush=1 or state≠IDLE. On accept: latch op, tag, src, sign flags; pointer ← granted+1 mod NREQ.
- Accept with b==0: result = all ones (DIV/DIVU) or a (REM/REMU); go RESP, core not started.
- Accept with signed op, a==INT_MIN, b==−1: result = INT_MIN (DIV) or 0 (REM); go RESP.
- Otherwise go START: core_a=|a|, core_b=|b| for signed ops, raw for unsigned; core_start=1 for exactly this cycle; next BUSY.
- BUSY: on core_done, select quo (DIV/DIVU) or rem (REM/REMU); signed fix-up: negate quotient if sign(a)≠sign(b), negate remainder if a<0; register into rsp_data; go RESP.
- RESP: rsp_valid=1, data/tag/src stable; on rsp_ready go IDLE.
- flush: IDLE → no accept; START or BUSY → DRAIN (core_done discarded; START still issues its core_start pulse, and core_start is deasserted from the next cycle); DRAIN → stays until core_done, then IDLE; RESP → drop rsp_valid, go IDLE. core_done coinciding with flush in BUSY: discarded, go IDLE.
- core_done outside BUSY/DRAIN is ignored.

## Timing
- Reset: state IDLE, pointer 0; req_ready, core_start, rsp_valid = 0; core_a, core_b, rsp_data, rsp_tag, rsp_src = 0.
- Reset mid-operation returns to IDLE immediately; core shares rst, so no stale core_done is expected; any that arrives is ignored.
- Accept cycle t: core_start at t+1; core_done at t+1+L (L = core latency); rsp_valid at t+2+L.
- Fast path: rsp_valid at t+1.
- At most one operation in flight; next accept no earlier than the cycle after rsp handshake or DRAIN exit.
- rsp_valid never depends combinationally on rsp_ready; req_ready depends combinationally only on req_valid, flush, state, pointer.

## Structure
- Package div_pkg: div_op_e (DIV, DIVU, REM, REMU), div_state_e, XLEN default, opcode width constant.
- Sub-module div_rr_arb: NREQ-wide round-robin arbiter (valid vector, enable, pointer update → one-hot grant + index).
- Sign pre-/post-correction and special-case detection stay inline.

## Test plan
- DIV a=0xFFFFFFF9 (−7), b=2 on req0 → rsp_data 0xFFFFFFFD, rsp_tag echoed, rsp_src 0; REM same operands → 0xFFFFFFFF.
- DIVU a=0xFFFFFFFF, b=0 → 0xFFFFFFFF at t+1, core_start never asserted; REMU a=0x1234, b=0 → 0x1234.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM → 0x00000000; no core_start.
- req0 and req1 valid continuously, rsp_ready=1 → grants alternate 0,1,0,1; rsp_src matches.
- flush two cycles into BUSY → no rsp_valid, req_ready stays 0 until core_done, then next request accepted.
- rsp_ready held 0 for 5 cycles in RESP → rsp_valid/data/tag stable, all req_ready 0; flush during hold → rsp_valid drops next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider scheduler.
package div_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned OP_W     = 2;

  typedef enum logic [OP_W-1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DRAIN,
    S_RESP
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_rr_arb.sv
// Round-robin arbiter: searches from the pointer upward, advances past the winner.
module div_rr_arb #(
  parameter int unsigned NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          valid,
  input  logic                     en,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  idx,
  output logic                     any
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int unsigned i);
    int unsigned s;
    s = 32'(p) + i;
    if (s >= NREQ) s -= NREQ;
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (en && !any && valid[wrap_add(ptr_q, i)]) begin
        any                      = 1'b1;
        idx                      = wrap_add(ptr_q, i);
        grant[wrap_add(ptr_q, i)] = 1'b1;
      end
    end
    ptr_d = any ? wrap_add(idx, 1) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/div_sched.sv
// Shares one unsigned multi-cycle divider among NREQ requesters, with RISC-V
// signed fix-up, divide-by-zero / overflow short-circuit and flush support.
module div_sched
  import div_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*XLEN-1:0]     req_a,
  input  logic [NREQ*XLEN-1:0]     req_b,
  input  logic [NREQ*OP_W-1:0]     req_op,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  output logic                     core_start,
  output logic [XLEN-1:0]          core_a,
  output logic [XLEN-1:0]          core_b,
  input  logic                     core_done,
  input  logic [XLEN-1:0]          core_quo,
  input  logic [XLEN-1:0]          core_rem,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_data,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [$clog2(NREQ)-1:0]  rsp_src
);

  localparam int unsigned   IDX_W   = $clog2(NREQ);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e        state_q, state_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_q, neg_d;
  logic              core_start_q, core_start_d;
  logic [XLEN-1:0]   core_a_q, core_a_d, core_b_q, core_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [IDX_W-1:0]  rsp_src_q, rsp_src_d;

  logic              arb_en, accept;
  logic [IDX_W-1:0]  gnt_idx;
  logic [XLEN-1:0]   sel_a, sel_b, mag_a, mag_b, core_res;
  logic [TAG_W-1:0]  sel_tag;
  div_op_e           sel_op;
  logic              sel_signed, sel_rem, a_neg, b_neg;

  assign arb_en = (state_q == S_IDLE) && !flush;

  div_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (req_valid),
    .en    (arb_en),
    .grant (req_ready),
    .idx   (gnt_idx),
    .any   (accept)
  );

  always_comb begin
    sel_a      = req_a[32'(gnt_idx)*XLEN +: XLEN];
    sel_b      = req_b[32'(gnt_idx)*XLEN +: XLEN];
    sel_tag    = req_tag[32'(gnt_idx)*TAG_W +: TAG_W];
    sel_op     = div_op_e'(req_op[32'(gnt_idx)*OP_W +: OP_W]);
    sel_signed = op_is_signed(sel_op);
    sel_rem    = op_is_rem(sel_op);
    a_neg      = sel_signed && sel_a[XLEN-1];
    b_neg      = sel_signed && sel_b[XLEN-1];
    mag_a      = a_neg ? -sel_a : sel_a;
    mag_b      = b_neg ? -sel_b : sel_b;
    core_res   = is_rem_q ? core_rem : core_quo;
  end

  always_comb begin
    state_d      = state_q;
    is_rem_d     = is_rem_q;
    neg_d        = neg_q;
    core_start_d = 1'b0;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_src_d    = rsp_src_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_rem_d  = sel_rem;
          // Remainder takes the dividend's sign; quotient is negative when signs differ.
          neg_d     = sel_rem ? a_neg : (a_neg ^ b_neg);
          rsp_tag_d = sel_tag;
          rsp_src_d = gnt_idx;
          if (sel_b == '0) begin
            rsp_data_d  = sel_rem ? sel_a : '1;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else if (sel_signed && (sel_a == INT_MIN) && (sel_b == '1)) begin
            rsp_data_d  = sel_rem ? '0 : INT_MIN;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            core_a_d     = mag_a;
            core_b_d     = mag_b;
            core_start_d = 1'b1;
            state_d      = S_START;
          end
        end
      end
      S_START: state_d = flush ? S_DRAIN : S_BUSY;
      S_BUSY: begin
        if (flush) begin
          state_d = core_done ? S_IDLE : S_DRAIN;
        end else if (core_done) begin
          rsp_data_d  = neg_q ? -core_res : core_res;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_DRAIN: if (core_done) state_d = S_IDLE;
      S_RESP: begin
        if (flush || rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      is_rem_q     <= 1'b0;
      neg_q        <= 1'b0;
      core_start_q <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_tag_q    <= '0;
      rsp_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      is_rem_q     <= is_rem_d;
      neg_q        <= neg_d;
      core_start_q <= core_start_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_src_q    <= rsp_src_d;
    end
  end

  assign core_start = core_start_q;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_src    = rsp_src_q;

endmodule
